axis_stream_sink: RTL and testbench
===================================

Name: axis_stream_sink

Overview:
- Synthesizable AXI-Stream consumer (slave end) for switch bring-up and bench/FPGA self-test; terminates one switch output port.
- Drives a configurable/pseudo-random TREADY pattern, checks the producer-side handshake stability rules in hardware, and reports per-packet statistics (length, ID, first-beat USER, XOR checksum) plus running beat/packet counters.

Parameters:
T_DATA_WIDTH, 8, TDATA width
T_ID_WIDTH, 8, TID width
T_USER_WIDTH, 8, TUSER width
LEN_WIDTH, 16, packet length counter width (beats)
LFSR_SEED, 16'hACE1, nonzero reset seed of ready LFSR

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_id  in  T_ID_WIDTH  stream TID
s_data  in  T_DATA_WIDTH  stream TDATA
s_user  in  T_USER_WIDTH  stream TUSER
s_last  in  1  stream TLAST
s_valid  in  1  stream TVALID
s_ready  out  1  stream TREADY
cfg_ready_mode  in  2  0=always, 1=never, 2=LFSR, 3=periodic
cfg_ready_thresh  in  8  LFSR threshold / period-1
pkt_valid  out  1  one-cycle strobe: packet complete
pkt_id  out  T_ID_WIDTH  TID of first beat
pkt_user  out  T_USER_WIDTH  TUSER of first beat
pkt_len  out  LEN_WIDTH  beats in packet incl. last
pkt_xor  out  T_DATA_WIDTH  XOR of all TDATA beats
beat_cnt  out  32  total accepted beats (wraps)
pkt_cnt  out  32  total completed packets (wraps)
err_flags  out  7  sticky protocol error bits
err_clear  in  1  clears err_flags

Behaviour:
- Reset: s_ready=0, pkt_valid=0, pkt_* =0, beat_cnt=pkt_cnt=0, err_flags=0, LFSR=LFSR_SEED, in_pkt=0, accumulators=0, stall history cleared.
- Handshake hs = s_valid & s_ready, sampled at posedge clk.
- s_ready registered (one-cycle decision latency); next value per mode:
  - 0: 1. 1: 0.
  - 2: LFSR (16-bit Galois, taps 16,14,13,11) advances every cycle; ready_next = (lfsr[7:0] < cfg_ready_thresh). thresh=0 → never ready.
  - 3: period counter 0..thresh; ready_next=1 only when counter==0 (1 of thresh+1 cycles; thresh=0 → always ready).
- Sink may deassert s_ready without a handshake; this is legal for the consumer.
- Mode change takes effect on the next s_ready update; in-flight packet state is unaffected.
- Stall check: stall_q <= s_valid & ~s_ready plus registered copies of id/data/user/last. If stall_q, on the current cycle set:
  - bit0: s_valid==0
  - bit1: id changed
  - bit2: data changed
  - bit3: user changed
  - bit4: last changed
- The cycle after reset deassertion is never checked.
- Packet FSM, states IDLE / IN_PKT:
  - IDLE + hs: capture id/user, len=1, xor=data. If s_last, complete immediately (1-beat packet); else → IN_PKT.
  - IN_PKT + hs: len+1 (saturates at all-ones, sets bit6), xor^=data. s_id != captured id sets bit5. If s_last → IDLE.
- Completion: pkt_valid pulses for exactly 1 cycle, the cycle after the last-beat hs. pkt_* stay valid until the next completion.
- Back-to-back: a packet's last beat and the next packet's first beat on consecutive cycles are handled without bubble.
- beat_cnt +1 per hs; pkt_cnt +1 per completion; both wrap modulo 2^32.
- err_flags: sticky. err_clear zeroes them, but a new error detected in the same cycle wins (bit set).
- Reset mid-packet: accumulators discarded, no pkt_valid, FSM → IDLE.

Decomposition:
- Package axis_sink_pkg: ready-mode enum (READY_ALWAYS, READY_NEVER, READY_LFSR, READY_PERIODIC), FSM state enum, err bit index localparams (ERR_VLD_DROP..ERR_LEN_OVF), LFSR tap constant.
- One sub-module: axis_ready_gen (LFSR + period counter + registered s_ready).
- Stability checker and packet FSM stay in the top level.

Test Plan:
- Mode 0; 3-beat packet id=5, data 0x11,0x22,0x44, user first=0x7 → pkt_valid 1 cycle after last hs; pkt_len=3, pkt_xor=0x77, pkt_id=5, pkt_user=7; beat_cnt=3, pkt_cnt=1; err_flags=0.
- Mode 1, producer holds valid 4 cycles then drops valid → err_flags=7'b0000001, no beats counted. Then err_clear → 0.
- Mode 1, data changes 0x10→0x11 while stalled → bit2 set only; same cycle as err_clear → bit2 remains set.
- Mode 2 thresh=128, 1000 random single/multi-beat packets from a compliant driver → err_flags=0; pkt_cnt and per-packet len/xor match scoreboard. Ready duty ≈50%.
- Mode 0, packet beats with id 3,3,4 → bit5 set; pkt_id=3, pkt_len=3. Back-to-back 1-beat packets each cycle → pkt_valid high every cycle.
- Reset asserted after beat 2 of a 5-beat packet → no pkt_valid; counters=0. Next 2-beat packet reports pkt_len=2.

Source files
------------

// File: rtl/axis_sink_pkg.sv
// rtl/axis_sink_pkg.sv - shared types and constants for the AXI-Stream sink
// Contents: ready-mode enum, packet FSM state enum, err_flags bit indices, LFSR tap mask.
package axis_sink_pkg;

   typedef enum logic [1:0] {
      READY_ALWAYS   = 2'd0,
      READY_NEVER    = 2'd1,
      READY_LFSR     = 2'd2,
      READY_PERIODIC = 2'd3
   } ready_mode_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_IN_PKT = 1'b1
   } pkt_state_e;

   localparam int ERR_VLD_DROP  = 0;
   localparam int ERR_ID_CHG    = 1;
   localparam int ERR_DATA_CHG  = 2;
   localparam int ERR_USER_CHG  = 3;
   localparam int ERR_LAST_CHG  = 4;
   localparam int ERR_ID_MIX    = 5;
   localparam int ERR_LEN_OVF   = 6;
   localparam int ERR_W         = 7;

   // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/axis_ready_gen.sv
// rtl/axis_ready_gen.sv - registered TREADY pattern generator
// Ports: clk, reset (sync, active-high); cfg_ready_mode/cfg_ready_thresh select the
// pattern; ready is the registered TREADY driven to the producer.
module axis_ready_gen
   import axis_sink_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] cfg_ready_mode,
   input  logic [7:0] cfg_ready_thresh,
   output logic       ready
);

   logic [15:0] lfsr;
   logic [7:0]  period_cnt;
   logic        ready_next;

   always_comb begin
      ready_next = 1'b0;
      case (ready_mode_e'(cfg_ready_mode))
         READY_ALWAYS:   ready_next = 1'b1;
         READY_NEVER:    ready_next = 1'b0;
         READY_LFSR:     ready_next = (lfsr[7:0] < cfg_ready_thresh);
         READY_PERIODIC: ready_next = (period_cnt == 8'd0);
         default:        ready_next = 1'b0;
      endcase
   end

   // LFSR and period counter free-run in every mode so a mode switch
   // picks up the pattern mid-stream without a restart.
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr       <= LFSR_SEED;
         period_cnt <= 8'd0;
         ready      <= 1'b0;
      end else begin
         lfsr       <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
         period_cnt <= (period_cnt >= cfg_ready_thresh) ? 8'd0 : period_cnt + 8'd1;
         ready      <= ready_next;
      end
   end

endmodule

// File: rtl/axis_stream_sink.sv
// rtl/axis_stream_sink.sv - AXI-Stream consumer with protocol checker and packet statistics
// Ports: clk, reset (sync, active-high); s_* is the consumed stream (s_ready driven here);
// cfg_ready_* shape TREADY; pkt_* report the last completed packet with a pkt_valid strobe;
// beat_cnt/pkt_cnt are wrapping totals; err_flags are sticky, cleared by err_clear.
module axis_stream_sink
   import axis_sink_pkg::*;
#(
   parameter int          T_DATA_WIDTH = 8,
   parameter int          T_ID_WIDTH   = 8,
   parameter int          T_USER_WIDTH = 8,
   parameter int          LEN_WIDTH    = 16,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [T_ID_WIDTH-1:0]   s_id,
   input  logic [T_DATA_WIDTH-1:0] s_data,
   input  logic [T_USER_WIDTH-1:0] s_user,
   input  logic                    s_last,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [1:0]              cfg_ready_mode,
   input  logic [7:0]              cfg_ready_thresh,
   output logic                    pkt_valid,
   output logic [T_ID_WIDTH-1:0]   pkt_id,
   output logic [T_USER_WIDTH-1:0] pkt_user,
   output logic [LEN_WIDTH-1:0]    pkt_len,
   output logic [T_DATA_WIDTH-1:0] pkt_xor,
   output logic [31:0]             beat_cnt,
   output logic [31:0]             pkt_cnt,
   output logic [6:0]              err_flags,
   input  logic                    err_clear
);

   logic hs;
   assign hs = s_valid & s_ready;

   axis_ready_gen #(.LFSR_SEED(LFSR_SEED)) u_ready_gen (
      .clk              (clk),
      .reset            (reset),
      .cfg_ready_mode   (cfg_ready_mode),
      .cfg_ready_thresh (cfg_ready_thresh),
      .ready            (s_ready)
   );

   // Snapshot of the previous cycle, used to spot a producer that changes
   // or withdraws a beat it offered while s_ready was low.
   logic                    stall_q;
   logic [T_ID_WIDTH-1:0]   id_q;
   logic [T_DATA_WIDTH-1:0] data_q;
   logic [T_USER_WIDTH-1:0] user_q;
   logic                    last_q;

   pkt_state_e              state;
   logic [T_ID_WIDTH-1:0]   cur_id;
   logic [T_USER_WIDTH-1:0] cur_user;
   logic [LEN_WIDTH-1:0]    cur_len;
   logic [T_DATA_WIDTH-1:0] cur_xor;
   logic [LEN_WIDTH-1:0]    len_inc;
   logic [ERR_W-1:0]        err_new;

   assign len_inc = (cur_len == '1) ? cur_len : cur_len + LEN_WIDTH'(1);

   always_comb begin
      err_new = '0;
      if (stall_q) begin
         err_new[ERR_VLD_DROP] = ~s_valid;
         err_new[ERR_ID_CHG]   = (s_id   != id_q);
         err_new[ERR_DATA_CHG] = (s_data != data_q);
         err_new[ERR_USER_CHG] = (s_user != user_q);
         err_new[ERR_LAST_CHG] = (s_last != last_q);
      end
      if (hs && state == ST_IN_PKT) begin
         err_new[ERR_ID_MIX]  = (s_id != cur_id);
         err_new[ERR_LEN_OVF] = (cur_len == '1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q   <= 1'b0;
         id_q      <= '0;
         data_q    <= '0;
         user_q    <= '0;
         last_q    <= 1'b0;
         state     <= ST_IDLE;
         cur_id    <= '0;
         cur_user  <= '0;
         cur_len   <= '0;
         cur_xor   <= '0;
         pkt_valid <= 1'b0;
         pkt_id    <= '0;
         pkt_user  <= '0;
         pkt_len   <= '0;
         pkt_xor   <= '0;
         beat_cnt  <= '0;
         pkt_cnt   <= '0;
         err_flags <= '0;
      end else begin
         stall_q   <= s_valid & ~s_ready;
         id_q      <= s_id;
         data_q    <= s_data;
         user_q    <= s_user;
         last_q    <= s_last;
         pkt_valid <= 1'b0;
         // A newly detected error outranks a simultaneous clear.
         err_flags <= (err_clear ? '0 : err_flags) | err_new;

         if (hs) begin
            beat_cnt <= beat_cnt + 32'd1;
            case (state)
               ST_IDLE: begin
                  cur_id   <= s_id;
                  cur_user <= s_user;
                  cur_len  <= LEN_WIDTH'(1);
                  cur_xor  <= s_data;
                  if (s_last) begin
                     pkt_valid <= 1'b1;
                     pkt_cnt   <= pkt_cnt + 32'd1;
                     pkt_id    <= s_id;
                     pkt_user  <= s_user;
                     pkt_len   <= LEN_WIDTH'(1);
                     pkt_xor   <= s_data;
                  end else begin
                     state <= ST_IN_PKT;
                  end
               end
               ST_IN_PKT: begin
                  cur_len <= len_inc;
                  cur_xor <= cur_xor ^ s_data;
                  if (s_last) begin
                     pkt_valid <= 1'b1;
                     pkt_cnt   <= pkt_cnt + 32'd1;
                     pkt_id    <= cur_id;
                     pkt_user  <= cur_user;
                     pkt_len   <= len_inc;
                     pkt_xor   <= cur_xor ^ s_data;
                     state     <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_axis_stream_sink.sv
// tb/tb_axis_stream_sink.sv - scoreboard testbench for axis_stream_sink
module tb_axis_stream_sink;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  s_id, s_data, s_user;
   logic        s_last, s_valid, s_ready;
   logic [1:0]  cfg_ready_mode;
   logic [7:0]  cfg_ready_thresh;
   logic        pkt_valid;
   logic [7:0]  pkt_id, pkt_user, pkt_xor;
   logic [15:0] pkt_len;
   logic [31:0] beat_cnt, pkt_cnt;
   logic [6:0]  err_flags;
   logic        err_clear;

   always #5 clk = ~clk;

   axis_stream_sink dut (
      .clk(clk), .reset(reset),
      .s_id(s_id), .s_data(s_data), .s_user(s_user), .s_last(s_last),
      .s_valid(s_valid), .s_ready(s_ready),
      .cfg_ready_mode(cfg_ready_mode), .cfg_ready_thresh(cfg_ready_thresh),
      .pkt_valid(pkt_valid), .pkt_id(pkt_id), .pkt_user(pkt_user),
      .pkt_len(pkt_len), .pkt_xor(pkt_xor),
      .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt),
      .err_flags(err_flags), .err_clear(err_clear)
   );

   typedef struct packed {
      logic [7:0]  id;
      logic [7:0]  user;
      logic [15:0] len;
      logic [7:0]  xr;
   } pkt_t;

   pkt_t       exp_q[$];
   logic [7:0] b_id[$], b_data[$], b_user[$];
   int         vectors = 0;
   int         miscompares = 0;
   int         exp_beats = 0;
   int         exp_pkts = 0;
   logic       count_duty = 1'b0;
   int         duty_cyc = 0;
   int         duty_hi = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every completion strobe must match the oldest issued packet.
   initial begin
      pkt_t e;
      forever begin
         @(negedge clk);
         if (count_duty) begin
            duty_cyc++;
            if (s_ready) duty_hi++;
         end
         if (!reset && pkt_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pkt_valid", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("pkt_id",   32'(pkt_id),   32'(e.id));
               chk("pkt_user", 32'(pkt_user), 32'(e.user));
               chk("pkt_len",  32'(pkt_len),  32'(e.len));
               chk("pkt_xor",  32'(pkt_xor),  32'(e.xr));
            end
         end
      end
   end

   // Compliant producer: beat held stable until s_ready is seen; called and returns at negedge.
   task automatic drive_beat(input logic [7:0] id, input logic [7:0] data,
                             input logic [7:0] user, input logic last);
      int n = 0;
      s_valid = 1'b1; s_id = id; s_data = data; s_user = user; s_last = last;
      while (!s_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("ready_within_budget", 32'(s_ready), 32'd1);
      @(negedge clk);
   endtask

   task automatic build(input int n, input logic [7:0] id, input logic [7:0] user0);
      b_id.delete(); b_data.delete(); b_user.delete();
      for (int i = 0; i < n; i++) begin
         b_id.push_back(id);
         b_data.push_back(8'($urandom));
         b_user.push_back(i == 0 ? user0 : 8'($urandom));
      end
   endtask

   // Reference: a packet is its first beat's id/user, its beat count and the XOR of its data.
   task automatic issue_pkt();
      pkt_t p;
      p.id = b_id[0]; p.user = b_user[0]; p.len = 16'(b_id.size()); p.xr = 8'h00;
      foreach (b_data[i]) p.xr ^= b_data[i];
      exp_q.push_back(p);
      exp_pkts++;
      for (int i = 0; i < b_id.size(); i++) begin
         drive_beat(b_id[i], b_data[i], b_user[i], i == b_id.size() - 1);
         exp_beats++;
      end
   endtask

   task automatic count_ready(input int cycles, output int hi);
      hi = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (s_ready) hi++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      reset = 1'b1; s_valid = 1'b0; s_id = '0; s_data = '0; s_user = '0; s_last = 1'b0;
      cfg_ready_mode = 2'd0; cfg_ready_thresh = 8'd0; err_clear = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
      chk("rst_beat_cnt", beat_cnt, 32'd0);
      chk("rst_pkt_cnt", pkt_cnt, 32'd0);
      chk("rst_err", 32'(err_flags), 32'd0);
      chk("rst_pkt_len", 32'(pkt_len), 32'd0);

      // Mode 0: fixed 3-beat packet.
      reset = 1'b0;
      build(3, 8'd5, 8'h07);
      b_data[0] = 8'h11; b_data[1] = 8'h22; b_data[2] = 8'h44;
      issue_pkt();
      chk("pulse_after_last_hs", 32'(pkt_valid), 32'd1);
      s_valid = 1'b0;
      @(negedge clk);
      chk("pulse_one_cycle", 32'(pkt_valid), 32'd0);
      chk("beat_cnt_3", beat_cnt, 32'd3);
      chk("pkt_cnt_1", pkt_cnt, 32'd1);
      chk("err_clean", 32'(err_flags), 32'd0);

      // Mode 1: valid withdrawn while stalled.
      cfg_ready_mode = 2'd1;
      repeat (2) @(negedge clk);
      s_valid = 1'b1; s_id = 8'd1; s_data = 8'h55; s_user = 8'd2; s_last = 1'b1;
      repeat (4) @(negedge clk);
      s_valid = 1'b0;
      @(negedge clk);
      chk("err_vld_drop", 32'(err_flags), 32'h01);
      chk("no_beats_stalled", beat_cnt, 32'd3);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      chk("err_cleared", 32'(err_flags), 32'd0);

      // Mode 1: data changes while stalled, then again concurrently with err_clear.
      s_valid = 1'b1; s_data = 8'h10;
      repeat (2) @(negedge clk);
      s_data = 8'h11;
      @(negedge clk);
      chk("err_data_chg", 32'(err_flags), 32'h04);
      s_data = 8'h12; err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      chk("err_new_beats_clear", 32'(err_flags), 32'h04);
      s_valid = 1'b0;
      @(negedge clk);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      chk("err_cleared_2", 32'(err_flags), 32'd0);

      // Ready pattern shapes.
      cfg_ready_mode = 2'd3; cfg_ready_thresh = 8'd3;
      repeat (3) @(negedge clk);
      count_ready(40, hi);
      chk("periodic_1_of_4", 32'(hi), 32'd10);
      cfg_ready_thresh = 8'd0;
      repeat (2) @(negedge clk);
      count_ready(20, hi);
      chk("periodic_thresh0_always", 32'(hi), 32'd20);
      cfg_ready_mode = 2'd2;
      repeat (2) @(negedge clk);
      count_ready(20, hi);
      chk("lfsr_thresh0_never", 32'(hi), 32'd0);

      // Mode 0: interleaved id inside a packet, then back-to-back 1-beat packets.
      cfg_ready_mode = 2'd0;
      build(3, 8'd3, 8'h09);
      b_id[2] = 8'd4;
      issue_pkt();
      s_valid = 1'b0;
      @(negedge clk);
      chk("err_id_mix", 32'(err_flags), 32'h20);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      for (int k = 0; k < 4; k++) begin
         build(1, 8'(k + 20), 8'(k));
         issue_pkt();
         chk("b2b_pkt_valid", 32'(pkt_valid), 32'd1);
      end
      s_valid = 1'b0;
      @(negedge clk);
      chk("beat_cnt_b2b", beat_cnt, 32'(exp_beats));
      chk("pkt_cnt_b2b", pkt_cnt, 32'(exp_pkts));

      // Reset in the middle of a 5-beat packet.
      drive_beat(8'd9, 8'hA1, 8'h01, 1'b0);
      drive_beat(8'd9, 8'hA2, 8'h02, 1'b0);
      s_valid = 1'b0; reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("midpkt_rst_pkt_valid", 32'(pkt_valid), 32'd0);
      chk("midpkt_rst_beat_cnt", beat_cnt, 32'd0);
      chk("midpkt_rst_pkt_cnt", pkt_cnt, 32'd0);
      exp_beats = 0; exp_pkts = 0;
      reset = 1'b0;
      build(2, 8'd6, 8'h33);
      issue_pkt();
      s_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_pkt_len", 32'(pkt_len), 32'd2);
      chk("post_rst_pkt_cnt", pkt_cnt, 32'd1);

      // Mode 2: random traffic with LFSR backpressure.
      cfg_ready_mode = 2'd2; cfg_ready_thresh = 8'd128;
      count_duty = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         build(int'($urandom_range(1, 4)), 8'($urandom), 8'($urandom));
         issue_pkt();
         if ($urandom_range(0, 2) != 0) begin
            s_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
         end
      end
      s_valid = 1'b0;
      count_duty = 1'b0;
      repeat (3) @(negedge clk);
      chk("rand_err_clean", 32'(err_flags), 32'd0);
      chk("rand_pkt_cnt", pkt_cnt, 32'(exp_pkts));
      chk("rand_beat_cnt", beat_cnt, 32'(exp_beats));
      chk("lfsr_duty_near_half",
          32'((duty_hi * 100 > duty_cyc * 35) && (duty_hi * 100 < duty_cyc * 65)), 32'd1);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
